// File: rtl/gate_response_checker_if.sv
// gate_response_checker_if: stimulus/observation bundle between a gate test source and the checker
interface gate_response_checker_if #(parameter int CNT_W = 8);
    logic             A;
    logic             B;
    logic             Z;
    logic             sample_valid;
    logic             clear;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] fail_count;
    logic [3:0]       coverage;
    logic [1:0]       first_fail_vec;
    logic             first_fail_valid;
    logic [1:0]       state;
    logic             done;
    logic             pass;

    modport master (
        output A, B, Z, sample_valid, clear,
        input  pass_count, fail_count, coverage, first_fail_vec, first_fail_valid, state, done, pass
    );

    modport slave (
        input  A, B, Z, sample_valid, clear,
        output pass_count, fail_count, coverage, first_fail_vec, first_fail_valid, state, done, pass
    );
endinterface

// File: rtl/gate_response_checker.sv
// gate_response_checker: compares a two-input gate's output against a truth table and tracks a check session
module gate_response_checker #(
    parameter logic [3:0] FUNC  = 4'b1110,
    parameter int         CNT_W = 8
) (
    input logic                    clk,
    input logic                    rst,
    gate_response_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, COMPLETE = 2'd2} state_t;

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    state_t           st, st_n;
    logic [CNT_W-1:0] pc, pc_n, fc, fc_n;
    logic [3:0]       cov, cov_n, cov_hit;
    logic [1:0]       vec, ffvec, ffvec_n;
    logic             hit, miss, ffv, ffv_n, done_r, pass_r, done_n, pass_n;

    assign vec     = {bus.A, bus.B};
    assign hit     = bus.sample_valid && (bus.Z == FUNC[vec]);
    assign miss    = bus.sample_valid && (bus.Z != FUNC[vec]);
    assign cov_hit = cov | (4'b0001 << vec);

    // next-session values; clear wins over a same-cycle sample, which is dropped
    assign pc_n    = bus.clear ? '0 : (hit && pc != MAX) ? pc + 1'b1 : pc;
    assign fc_n    = bus.clear ? '0 : (miss && fc != MAX) ? fc + 1'b1 : fc;
    assign cov_n   = bus.clear ? 4'b0000 : bus.sample_valid ? cov_hit : cov;
    assign ffv_n   = bus.clear ? 1'b0 : ffv | miss;
    assign ffvec_n = bus.clear ? 2'b00 : (miss && !ffv) ? vec : ffvec;
    assign st_n    = bus.clear ? IDLE : !bus.sample_valid ? st :
                     (st == COMPLETE || cov_hit == 4'b1111) ? COMPLETE : RUN;
    assign done_n  = st_n == COMPLETE;
    assign pass_n  = done_n && fc_n == '0;

    // session state, counters and flags all update together so outputs stay coherent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= IDLE;
            pc     <= '0;
            fc     <= '0;
            cov    <= 4'b0000;
            ffv    <= 1'b0;
            ffvec  <= 2'b00;
            done_r <= 1'b0;
            pass_r <= 1'b0;
        end else begin
            st     <= st_n;
            pc     <= pc_n;
            fc     <= fc_n;
            cov    <= cov_n;
            ffv    <= ffv_n;
            ffvec  <= ffvec_n;
            done_r <= done_n;
            pass_r <= pass_n;
        end
    end

    assign bus.pass_count       = pc;
    assign bus.fail_count       = fc;
    assign bus.coverage         = cov;
    assign bus.first_fail_vec   = ffvec;
    assign bus.first_fail_valid = ffv;
    assign bus.state            = st;
    assign bus.done             = done_r;
    assign bus.pass             = pass_r;
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: directed vector checks of the gate response checker
module tb_gate_response_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    gate_response_checker_if #(.CNT_W(8)) g ();
    gate_response_checker_if #(.CNT_W(2)) s ();

    gate_response_checker #(.FUNC(4'b1110), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(g));
    gate_response_checker #(.FUNC(4'b1110), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(s));

    typedef struct packed {
        logic       a, b, z;
        logic [7:0] pc, fc;
        logic [3:0] cov;
        logic [1:0] st;
        logic       ffv;
        logic [1:0] ffvec;
        logic       dn, ps;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] pc, input logic [7:0] fc, input logic [3:0] cov,
                           input logic [1:0] st, input logic ffv, input logic [1:0] ffvec, input logic dn, input logic ps);
        chk({tag, ".pass_count"}, 32'(g.pass_count), 32'(pc));
        chk({tag, ".fail_count"}, 32'(g.fail_count), 32'(fc));
        chk({tag, ".coverage"}, 32'(g.coverage), 32'(cov));
        chk({tag, ".state"}, 32'(g.state), 32'(st));
        chk({tag, ".ff_valid"}, 32'(g.first_fail_valid), 32'(ffv));
        chk({tag, ".ff_vec"}, 32'(g.first_fail_vec), 32'(ffvec));
        chk({tag, ".done"}, 32'(g.done), 32'(dn));
        chk({tag, ".pass"}, 32'(g.pass), 32'(ps));
    endtask

    task automatic strobe(input logic a, input logic b, input logic z);
        @(negedge clk);
        g.A = a; g.B = b; g.Z = z; g.sample_valid = 1'b1; g.clear = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        g.sample_valid = 1'b0; g.clear = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        g.sample_valid = 1'b0; g.clear = 1'b1;
        @(negedge clk);
        g.clear = 1'b0;
    endtask

    initial begin
        // Z stuck at 0 against OR, then one more good sample while COMPLETE
        tbl[0] = '{1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 4'b0001, 2'd1, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 4'b0011, 2'd1, 1'b1, 2'b01, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'd1, 8'd2, 4'b0111, 2'd1, 1'b1, 2'b01, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 8'd1, 8'd3, 4'b1111, 2'd2, 1'b1, 2'b01, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 8'd2, 8'd3, 4'b1111, 2'd2, 1'b1, 2'b01, 1'b1, 1'b0};
        {g.A, g.B, g.Z, g.sample_valid, g.clear} = '0;
        {s.A, s.B, s.Z, s.sample_valid, s.clear} = '0;
        #12;
        chk_all("reset", 8'd0, 8'd0, 4'b0000, 2'd0, 1'b0, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            strobe(tbl[i].a, tbl[i].b, tbl[i].z);
            chk_all($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].fc, tbl[i].cov, tbl[i].st,
                    tbl[i].ffv, tbl[i].ffvec, tbl[i].dn, tbl[i].ps);
        end

        // clear beats a same-cycle sample
        @(negedge clk);
        g.A = 1'b1; g.B = 1'b0; g.Z = 1'b1; g.sample_valid = 1'b1; g.clear = 1'b1;
        @(posedge clk);
        #1;
        chk_all("clear", 8'd0, 8'd0, 4'b0000, 2'd0, 1'b0, 2'b00, 1'b0, 1'b0);

        strobe(1'b0, 1'b0, 1'b0);
        strobe(1'b0, 1'b1, 1'b1);
        strobe(1'b1, 1'b0, 1'b1);
        strobe(1'b1, 1'b1, 1'b1);
        chk_all("good", 8'd4, 8'd0, 4'b1111, 2'd2, 1'b0, 2'b00, 1'b1, 1'b1);

        // stimulus toggles without a strobe change nothing
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {g.A, g.B, g.Z} = 3'(i + 3);
        end
        @(negedge clk);
        chk_all("no_strobe", 8'd4, 8'd0, 4'b1111, 2'd2, 1'b0, 2'b00, 1'b1, 1'b1);

        do_clear();
        strobe(1'b0, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b0);
        strobe(1'b0, 1'b1, 1'b1);
        chk_all("partial", 8'd3, 8'd0, 4'b0011, 2'd1, 1'b0, 2'b00, 1'b0, 1'b0);

        // async reset mid-RUN takes effect between edges
        do_clear();
        strobe(1'b0, 1'b0, 1'b0);
        strobe(1'b0, 1'b1, 1'b1);
        idle();
        chk("pre_rst.pass_count", 32'(g.pass_count), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk_all("async_rst", 8'd0, 8'd0, 4'b0000, 2'd0, 1'b0, 2'b00, 1'b0, 1'b0);
        #1 rst = 1'b0;
        strobe(1'b1, 1'b1, 1'b1);
        chk_all("after_rst", 8'd1, 8'd0, 4'b1000, 2'd1, 1'b0, 2'b00, 1'b0, 1'b0);
        idle();

        // 2-bit counters saturate at 3
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s.A = 1'b1; s.B = 1'b1; s.Z = 1'b1; s.sample_valid = 1'b1;
        end
        @(negedge clk);
        s.sample_valid = 1'b0;
        chk("sat.pass_count", 32'(s.pass_count), 32'd3);
        chk("sat.fail_count", 32'(s.fail_count), 32'd0);
        chk("sat.coverage", 32'(s.coverage), 32'b1000);
        chk("sat.state", 32'(s.state), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
Synthesizable self-checking monitor and the observing end of the two-input gate stimulus flow. A stimulus source drives the A/B vector into the gate under test. This block samples A, B and the gate's Z output on a valid strobe. It compares Z against a parameterised truth table, counts passes and failures, tracks which input combinations have been covered, and latches the first failing vector. It sits beside any two-input gate UUT in lab benches and on-board checks.

Parameters:
FUNC  4'b1110  expected truth table; FUNC[{A,B}] is the expected Z (default = OR; AND=4'b1000, XOR=4'b0110, NAND=4'b0111)
CNT_W  8  width of pass/fail counters

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
A  input  1  gate input A as driven to the UUT
B  input  1  gate input B as driven to the UUT
Z  input  1  UUT output
sample_valid  input  1  A/B/Z are settled this cycle; sample them
clear  input  1  synchronous restart of the check session
pass_count  output  CNT_W  number of matching samples, saturating
fail_count  output  CNT_W  number of mismatching samples, saturating
coverage  output  4  bit {A,B} set once that combination has been sampled
first_fail_vec  output  2  {A,B} of the first mismatching sample
first_fail_valid  output  1  first_fail_vec holds a captured failure
state  output  2  current FSM state (IDLE=0, RUN=1, COMPLETE=2)
done  output  1  high in COMPLETE (all 4 combinations covered)
pass  output  1  done && fail_count==0

Behaviour:
- Reset (async, rst=1): all outputs 0; state=IDLE; counters 0; coverage 4'b0000; first_fail_vec 2'b00.
- clear (sync, rst=0): same values as reset on the next edge. clear takes priority over a same-cycle sample_valid, and that sample is discarded.
- Sampling: on a clk edge with sample_valid=1, the block computes exp=FUNC[{A,B}]:
  - Z==exp: pass_count +1.
  - Z!=exp: fail_count +1.
  - In both cases coverage[{A,B}] is set.
  - Outputs reflect the sample one cycle after the strobe; there is no combinational path from inputs to outputs.
- Saturation: a counter at 2^CNT_W-1 holds its value and does not wrap.
- First failure: on the first mismatch since reset/clear, the block captures first_fail_vec={A,B} and sets first_fail_valid=1. Later mismatches do not overwrite it.
- FSM:
  - IDLE -> RUN on the first sample_valid.
  - RUN -> COMPLETE on the edge where coverage becomes 4'b1111, including when that edge's sample completes coverage.
  - COMPLETE persists until clear or rst.
  - Samples in COMPLETE are still counted and compared; state is unchanged.
- done = (state==COMPLETE). pass = done && (fail_count==0), registered together with state.
- Repeated vectors: coverage bits are idempotent, but each valid strobe counts once.
- sample_valid held high for N cycles produces N samples.
- Reset asserted mid-session clears everything immediately, without waiting for a clock edge.
- Without sample_valid, A/B/Z toggles are ignored.

Test Plan:
- OR default, strobe vectors 00/0, 01/1, 10/1, 11/1 on consecutive cycles -> cycle after last strobe: pass_count=4, fail_count=0, coverage=4'b1111, done=1, pass=1, first_fail_valid=0.
- Faulty UUT with Z stuck at 0, vectors 00, 01, 10, 11 -> pass_count=1, fail_count=3, first_fail_vec=2'b01, first_fail_valid=1, done=1, pass=0.
- Vectors 00, 00, 01 only -> pass_count=3, coverage=4'b0011, state=RUN, done=0.
- CNT_W=2, 5 matching strobes of 11/1 -> pass_count=3 (saturated), coverage=4'b1000.
- After a full failing session, assert clear together with sample_valid (10/1) -> next cycle all counters 0, coverage 0, state=IDLE. Then 00/0, 01/1, 10/1, 11/1 -> pass=1.
- Assert rst between clock edges mid-RUN (pass_count=2) -> outputs go to 0 before the next clk edge. Deassert rst, then one 11/1 strobe -> pass_count=1, state=RUN.
